// File: rtl/data_packer.sv
// Word-to-frame packer: shifts M-bit words into an N-bit frame, LSB word first.
// Optional sticky drop flag on ovf_o when DATA_PACKER_OVF_EN is defined.
module data_packer #(
  parameter int N = 8192,
  parameter int M = 32,
  localparam int W = N / M,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [M-1:0]  data_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          valid_o,
  input  logic          rd_i,
  output logic [N-1:0]  data_o,
  output logic [CW-1:0] wcnt_o,
  output logic          ovf_o
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  logic [1:0]    state_r;
  logic [N-1:0]  data_r;
  logic [CW-1:0] wcnt_r;
  logic          accept;
  logic          is_fill;
  logic          is_flush;
  logic          is_full;
  logic          at_last;
  logic          do_flush;

  assign is_fill  = (state_r == S_FILL);
  assign is_flush = (state_r == S_FLUSH);
  assign is_full  = (state_r == S_FULL);
  assign accept   = wr_i && is_fill;
  assign at_last  = (wcnt_r == LAST);
  assign do_flush = flush_i && (wcnt_r != ZERO);

  assign ready_o = is_fill;
  assign valid_o = is_full;
  assign data_o  = data_r;
  assign wcnt_o  = wcnt_r;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= S_FILL;
      data_r  <= '0;
      wcnt_r  <= '0;
    end else if (clr_i) begin
      state_r <= S_FILL;
      data_r  <= '0;
      wcnt_r  <= '0;
    end else begin
      unique case (1'b1)
        is_fill: begin
          if (accept) begin
            data_r <= {data_i, data_r[N-1:M]};
            wcnt_r <= wcnt_r + ONE;
            if (at_last) begin
              state_r <= S_FULL;
            end else if (do_flush) begin
              state_r <= S_FLUSH;
            end
          end else if (do_flush) begin
            state_r <= S_FLUSH;
          end
        end
        is_flush: begin
          data_r <= {{M{1'b0}}, data_r[N-1:M]};
          wcnt_r <= wcnt_r + ONE;
          if (at_last) begin
            state_r <= S_FULL;
          end
        end
        is_full: begin
          // Old frame stays visible until the next word shifts in.
          if (rd_i) begin
            state_r <= S_FILL;
            wcnt_r  <= '0;
          end
        end
        default: begin
          state_r <= S_FILL;
          wcnt_r  <= '0;
        end
      endcase
    end
  end

`ifdef DATA_PACKER_OVF_EN
  logic ovf_r;

  // Sticky across clr_i; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_r <= 1'b0;
    end else if (wr_i && !ready_o) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf_o = ovf_r;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: doc/data_packer.md
Name: data_packer

Overview:
- Word-to-frame packer: accepts a stream of M-bit words and assembles them into one N-bit frame.
- It is the write-side counterpart of the readout frame shifter, which unloads N-bit frames LSB word first.
- Word order is the same: the first word accepted lands in data_o[M-1:0] and the last in data_o[N-1:N-M].
- Sits in the readout/test path to rebuild wide frames from 32-bit bus words, e.g. for loopback comparison against the shifter.

Parameters:
- N, 8192, frame width in bits; must be an integer multiple of M.
- M, 32, word width in bits.
- Derived: W = N/M words per frame; CW = clog2(W+1) word-counter width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear; drops any partial or full frame.
- wr_i  in  1  word valid; a word is accepted when wr_i && ready_o.
- data_i  in  M  input word.
- flush_i  in  1  close a partial frame, padding the remaining words with zeros.
- ready_o  out  1  packer can accept a word this cycle.
- valid_o  out  1  complete frame present on data_o.
- rd_i  in  1  frame consumed; sampled only while valid_o=1.
- data_o  out  N  assembled frame.
- wcnt_o  out  CW  words currently held, 0..W.
- ovf_o  out  1  overflow flag (see Optional Feature).

Behaviour:
- Reset (rst_n_i=0, async): state FILL, data_o=0, wcnt_o=0, ready_o=1, valid_o=0, ovf_o=0.
- Storage is a shift-in register, one operation per cycle:
  - data_r <= {data_i, data_r[N-1:M]} when a word is accepted.
  - data_r <= {M'b0, data_r[N-1:M]} on a pad step.
  - After W shifts, word 0 sits at bits [M-1:0].
- States FILL, FLUSH, FULL; ready_o=1 only in FILL; valid_o=1 only in FULL.
- FILL:
  - Accepted word: wcnt+1.
  - If the accepted word is word W (wcnt was W-1): next state FULL, wcnt=W, valid_o=1 the next cycle. Latency from last word to valid_o is 1 cycle.
  - flush_i with wcnt>0 and no word accepted that cycle: next state FLUSH.
  - flush_i with wcnt>0 and a word accepted the same cycle: the word is taken, then FLUSH (or FULL if that word completed the frame).
  - flush_i with wcnt=0: ignored; no empty frames are produced.
- FLUSH:
  - One zero-pad shift per cycle, wcnt+1, ready_o=0.
  - Reaching wcnt=W: next state FULL.
  - A flush from wcnt=k takes W-k cycles before valid_o rises.
- FULL:
  - data_o stable, wcnt_o=W.
  - wr_i and flush_i are ignored.
  - rd_i=1: next state FILL, wcnt=0, ready_o=1 the next cycle. data_o keeps the old frame until the first new word shifts in.
  - Back-to-back throughput: frame done -> rd_i -> next word, minimum one bubble cycle.
- rd_i outside FULL: ignored.
- clr_i (priority over wr_i, flush_i and rd_i): next state FILL, wcnt=0, data_r=0. ovf_o is not cleared by clr_i.
- wcnt never exceeds W and never wraps.
- Reset asserted mid-frame or mid-flush: immediate return to the reset values.

Optional Feature:
- Macro: DATA_PACKER_OVF_EN.
- Defined: ovf_o is a sticky flag, set one cycle after any cycle with wr_i=1 && ready_o=0 (dropped word). It is cleared only by rst_n_i.
- Undefined: ovf_o is tied to 0 and no flag logic is built.
- In both builds, dropped words never alter data_r or wcnt.

Test Plan:
1. N=128, M=32: write 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> one cycle after the 4th word, valid_o=1, data_o=0x44444444_33333333_22222222_11111111, ready_o=0, wcnt_o=4.
2. From 1, pulse rd_i -> next cycle valid_o=0, ready_o=1, wcnt_o=0; write 0xA..A x4 -> data_o=all 0xA.
3. Write 0xDEADBEEF, then flush_i -> 3 pad cycles with ready_o=0, then valid_o=1, data_o=0x00000000_00000000_00000000_DEADBEEF.
4. flush_i with wcnt_o=0 -> no state change, valid_o stays 0; flush_i together with the 4th word -> FULL after 1 cycle, no padding.
5. While FULL, drive wr_i=1 with 0x55555555 for 2 cycles -> data_o unchanged; ovf_o=1 with DATA_PACKER_OVF_EN, ovf_o=0 without.
6. After 2 words, assert clr_i together with wr_i -> wcnt_o=0, data_o=0; separately, pull rst_n_i low mid-flush -> all outputs return to reset values immediately, without waiting for a clock edge.
